// File: rtl/pll_reset_pkg.sv
// Shared types and sizing helpers for the PLL reset manager.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_rst_state_t;

  localparam int LOSS_CNT_W = 8;

  // One extra bit so a counter sized for the largest period never wraps on its last compare.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_manager_sync_2ff.sv
// Single-bit two-flop synchronizer for the asynchronous PLL lock indication.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_manager.sv
// Drives the PLL reset pulse, qualifies lock, retries or faults on timeout,
// and releases the pixel-domain reset once lock has been stable.
module pll_reset_manager
  import pll_reset_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RETRY_MAX           = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int CNT_W   = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int RETRY_W = $clog2(RETRY_MAX + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM    = RETRY_W'(RETRY_MAX);

  pll_rst_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RETRY_W-1:0]    retry_q, retry_d, retry_inc;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_rst_q, sys_rst_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;
  logic                  locked_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    retry_inc = retry_q + RETRY_W'(1);
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABILIZE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIM) ? ST_FAULT : ST_RESET_PLL;
        end
      end
      ST_STABILIZE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        // A lock loss takes precedence, so a coincident relock request is counted as a loss.
        if (!locked_s) begin
          state_d = ST_RESET_PLL;
          if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
        end else if (relock_req) begin
          state_d = ST_RESET_PLL;
        end
      end
      ST_FAULT: begin
        if (relock_req) begin
          state_d = ST_RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = ST_RESET_PLL;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign lock_loss_count = loss_q;

endmodule
